// File: rtl/ex_mem.sv
// ex_mem: EX -> MEM pipeline register.
//
// Captures the execute-stage results (GPR write address/enable/data and the
// HI/LO update) on every rising clock edge and presents them to the memory
// stage. It also holds the 64-bit partial product and cycle index that EX
// feeds back to itself while a two-cycle multiply-accumulate
// (MADD/MADDU/MSUB/MSUBU) is stalled in place.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active-high
//   stall[5:0] stall vector from ctrl; only stall[3] (EX held) and
//              stall[4] (MEM held) matter here
//   flush      pipeline flush; clears every register
//   ex_*       results from EX
//   hilo_i     partial product from EX (multiply-accumulate)
//   cnt_i      multiply-accumulate cycle index from EX
//   mem_*      registered ex_* toward MEM
//   hilo_o     held partial product, fed back to EX
//   cnt_o      held cycle index, fed back to EX
module ex_mem (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        flush,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    input  logic [31:0] ex_wdata,
    input  logic [31:0] ex_hi,
    input  logic [31:0] ex_lo,
    input  logic        ex_whilo,
    input  logic [63:0] hilo_i,
    input  logic [1:0]  cnt_i,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic [31:0] mem_wdata,
    output logic [31:0] mem_hi,
    output logic [31:0] mem_lo,
    output logic        mem_whilo,
    output logic [63:0] hilo_o,
    output logic [1:0]  cnt_o
);

    logic [4:0]  wd_reg,    wd_next;
    logic        wreg_reg,  wreg_next;
    logic [31:0] wdata_reg, wdata_next;
    logic [31:0] hi_reg,    hi_next;
    logic [31:0] lo_reg,    lo_next;
    logic        whilo_reg, whilo_next;
    logic [63:0] hilo_reg,  hilo_next;
    logic [1:0]  cnt_reg,   cnt_next;

    // Next-state selection. Default is "hold" (EX and MEM both stalled).
    // stall[3]=0 with stall[4]=1 cannot come from ctrl; it simply falls into
    // the advance branch because only stall[3] is tested there.
    always_comb begin
        wd_next    = wd_reg;
        wreg_next  = wreg_reg;
        wdata_next = wdata_reg;
        hi_next    = hi_reg;
        lo_next    = lo_reg;
        whilo_next = whilo_reg;
        hilo_next  = hilo_reg;
        cnt_next   = cnt_reg;
        if (flush || (stall[3] && !stall[4])) begin
            // Flush clears everything; a bubble clears the MEM-facing
            // fields but captures the multiply-accumulate feedback state.
            wd_next    = '0;
            wreg_next  = 1'b0;
            wdata_next = '0;
            hi_next    = '0;
            lo_next    = '0;
            whilo_next = 1'b0;
            hilo_next  = flush ? 64'd0 : hilo_i;
            cnt_next   = flush ? 2'd0 : cnt_i;
        end else if (!stall[3]) begin
            // Advance: pass EX results on, retire any feedback state.
            wd_next    = ex_wd;
            wreg_next  = ex_wreg;
            wdata_next = ex_wdata;
            hi_next    = ex_hi;
            lo_next    = ex_lo;
            whilo_next = ex_whilo;
            hilo_next  = '0;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_reg    <= '0;
            wreg_reg  <= 1'b0;
            wdata_reg <= '0;
            hi_reg    <= '0;
            lo_reg    <= '0;
            whilo_reg <= 1'b0;
            hilo_reg  <= '0;
            cnt_reg   <= '0;
        end else begin
            wd_reg    <= wd_next;
            wreg_reg  <= wreg_next;
            wdata_reg <= wdata_next;
            hi_reg    <= hi_next;
            lo_reg    <= lo_next;
            whilo_reg <= whilo_next;
            hilo_reg  <= hilo_next;
            cnt_reg   <= cnt_next;
        end
    end

    assign mem_wd    = wd_reg;
    assign mem_wreg  = wreg_reg;
    assign mem_wdata = wdata_reg;
    assign mem_hi    = hi_reg;
    assign mem_lo    = lo_reg;
    assign mem_whilo = whilo_reg;
    assign hilo_o    = hilo_reg;
    assign cnt_o     = cnt_reg;

endmodule

// File: tb/tb_ex_mem.sv
// Directed testbench for ex_mem. Every step drives inputs, takes one clock
// edge, and compares all outputs against hand-computed values.
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall;
    logic        flush;
    logic [4:0]  ex_wd;
    logic        ex_wreg;
    logic [31:0] ex_wdata;
    logic [31:0] ex_hi;
    logic [31:0] ex_lo;
    logic        ex_whilo;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg;
    logic [31:0] mem_wdata;
    logic [31:0] mem_hi;
    logic [31:0] mem_lo;
    logic        mem_whilo;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int total = 0;
    int bad   = 0;
    int illegal_cnt = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_whilo(ex_whilo),
        .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_whilo(mem_whilo),
        .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Watch for the stall pattern ctrl must never produce.
    always @(posedge clk) begin
        if (!stall[3] && stall[4]) begin
            illegal_cnt = illegal_cnt + 1;
            $display("note: illegal stall pattern %b seen at %0t", stall, $time);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag,
                           input logic [4:0] e_wd, input logic e_wreg,
                           input logic [31:0] e_wdata, input logic [31:0] e_hi,
                           input logic [31:0] e_lo, input logic e_whilo,
                           input logic [63:0] e_hilo, input logic [1:0] e_cnt);
        chk({tag, ".mem_wd"},    64'(mem_wd),    64'(e_wd));
        chk({tag, ".mem_wreg"},  64'(mem_wreg),  64'(e_wreg));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({tag, ".mem_hi"},    64'(mem_hi),    64'(e_hi));
        chk({tag, ".mem_lo"},    64'(mem_lo),    64'(e_lo));
        chk({tag, ".mem_whilo"}, 64'(mem_whilo), 64'(e_whilo));
        chk({tag, ".hilo_o"},    hilo_o,         e_hilo);
        chk({tag, ".cnt_o"},     64'(cnt_o),     64'(e_cnt));
        $display("step %-12s wd=%0d wreg=%0b wdata=%h hi=%h lo=%h whilo=%0b hilo=%h cnt=%0d",
                 tag, mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, hilo_o, cnt_o);
    endtask

    task automatic set_ex(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic [31:0] hi, input logic [31:0] lo, input logic whilo,
                          input logic [63:0] hl, input logic [1:0] cnt);
        ex_wd = wd; ex_wreg = wreg; ex_wdata = wdata;
        ex_hi = hi; ex_lo = lo; ex_whilo = whilo;
        hilo_i = hl; cnt_i = cnt;
    endtask

    initial begin
        // Reset with busy inputs.
        rst = 1'b1; flush = 1'b0; stall = 6'b0;
        set_ex(5'h1F, 1'b1, 32'hAAAA_5555, 32'h1111_1111, 32'h2222_2222, 1'b1,
               64'hFFFF_FFFF_FFFF_FFFF, 2'd3);
        tick(); chk_all("reset1", 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); chk_all("reset2", 0, 0, 0, 0, 0, 0, 0, 0);

        rst = 1'b0;
        set_ex(5'd3, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        tick(); chk_all("post_rst", 5'd3, 1, 32'h1234_5678, 0, 0, 0, 0, 0);

        // Advance stream; feedback inputs nonzero but must be ignored.
        for (int i = 0; i < 4; i++) begin
            set_ex(5'(i + 1), 1'b1, 32'h10 + 32'(i), 32'h0, 32'h0, 1'b0, 64'hABCD, 2'd2);
            tick();
            chk_all($sformatf("adv%0d", i), 5'(i + 1), 1, 32'h10 + 32'(i), 0, 0, 0, 0, 0);
        end

        // Bubble capturing multiply-accumulate feedback.
        stall = 6'b001111;
        set_ex(5'd5, 1'b1, 32'h77, 32'h0, 32'h0, 1'b0, 64'h0000_0002_0000_0004, 2'd1);
        tick(); chk_all("bubble", 0, 0, 0, 0, 0, 0, 64'h0000_0002_0000_0004, 2'd1);

        stall = 6'b0;
        set_ex(5'd5, 1'b1, 32'h77, 32'h2, 32'h9, 1'b1, 64'h1234, 2'd2);
        tick(); chk_all("madd_done", 5'd5, 1, 32'h77, 32'h2, 32'h9, 1, 0, 0);

        // Hold with MEM-facing state loaded.
        set_ex(5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 64'h0, 2'd0);
        tick(); chk_all("load7", 5'd7, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'(9 + i), 1'b0, 32'hCAFE_0000 + 32'(i), 32'h1, 32'h1, 1'b1,
                   64'h99 + 64'(i), 2'd3);
            tick();
            chk_all($sformatf("hold%0d", i), 5'd7, 1, 32'hDEAD_BEEF, 0, 0, 0, 0, 0);
        end
        stall = 6'b0;
        tick(); chk_all("hold_rel", 5'd11, 0, 32'hCAFE_0002, 32'h1, 32'h1, 1, 0, 0);

        // Hold with feedback state loaded via a bubble.
        stall = 6'b001111;
        set_ex(5'd7, 1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 64'h5, 2'd1);
        tick(); chk_all("bub5", 0, 0, 0, 0, 0, 0, 64'h5, 2'd1);
        stall = 6'b011111;
        for (int i = 0; i < 3; i++) begin
            set_ex(5'd4, 1'b1, 32'h4444, 32'h3, 32'h3, 1'b1, 64'h7 + 64'(i), 2'd2);
            tick();
            chk_all($sformatf("fbhold%0d", i), 0, 0, 0, 0, 0, 0, 64'h5, 2'd1);
        end
        stall = 6'b0;
        tick(); chk_all("fbhold_rel", 5'd4, 1, 32'h4444, 32'h3, 32'h3, 1, 0, 0);

        // Flush beats stall.
        stall = 6'b001111;
        set_ex(5'd6, 1'b1, 32'h6666, 32'h6, 32'h6, 1'b1, 64'hF00D, 2'd1);
        tick(); chk_all("pre_flush", 0, 0, 0, 0, 0, 0, 64'hF00D, 2'd1);
        flush = 1'b1;
        tick(); chk_all("flush", 0, 0, 0, 0, 0, 0, 0, 0);
        flush = 1'b0; stall = 6'b0;
        tick(); chk_all("post_flush", 5'd6, 1, 32'h6666, 32'h6, 32'h6, 1, 0, 0);
        rst = 1'b1;
        tick(); chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b0;

        // Illegal stall pattern behaves as advance.
        stall = 6'b010000;
        set_ex(5'h11, 1'b1, 32'h55AA, 32'h8, 32'h9, 1'b1, 64'hBEEF, 2'd1);
        tick(); chk_all("illegal", 5'h11, 1, 32'h55AA, 32'h8, 32'h9, 1, 0, 0);
        stall = 6'b0;
        tick();
        chk("illegal_flag", 64'(illegal_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
